shift_accumulator: RTL and testbench
====================================

SHIFT_ACCUMULATOR -- requirements
Module: shift_accumulator

Interface
REQ-001 The block SHALL have parameter PARALLELISM, default 8, the operand width entering the upstream barrel shifter.
REQ-002 The block SHALL have parameter DEPTH, default 3, the upstream shifter stage count.
REQ-003 The block SHALL have parameter NUM_TERMS, default 4, the maximum terms per group, with NUM_TERMS >= 1.
REQ-004 The block SHALL have derived localparams IN_W = PARALLELISM + 2**DEPTH, CNT_W = max(1, $clog2(NUM_TERMS+1)) and ACC_W = IN_W + $clog2(NUM_TERMS), with $clog2(1) taken as 0.
REQ-005 The block SHALL have these ports, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous abort of the current group.
- in_valid  input  1  a shifted term is presented.
- in_ready  output  1  the block accepts a term this cycle.
- in_data  input  IN_W  signed shifted partial product from the barrel shifter.
- in_last  input  1  the accepted term closes the group.
- out_valid  output  1  the group result is held.
- out_ready  input  1  the consumer accepts the result.
- out_data  output  ACC_W  signed group sum.
- out_count  output  CNT_W  number of terms in the group.

Function
REQ-006 A term SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-007 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-008 in_ready SHALL be 1 in IDLE and ACCUM, and SHALL equal out_ready in DONE.
REQ-009 On acceptance in IDLE, acc SHALL be set to sign-extended in_data and cnt to 1.
REQ-010 On acceptance in ACCUM, acc SHALL become acc + sign-extended in_data and cnt SHALL become cnt+1.
REQ-011 A group SHALL close on the accepted term where in_last=1 or where the new cnt equals NUM_TERMS, whichever comes first; the FSM then moves to DONE.
REQ-012 If an accepted term does not close the group, IDLE SHALL move to ACCUM and ACCUM SHALL stay in ACCUM.
REQ-013 With NUM_TERMS=1, every accepted term SHALL close its group.
REQ-014 In DONE, out_valid SHALL be 1, and out_data and out_count SHALL hold acc and cnt, stable until the handshake.
REQ-015 In DONE with out_ready=1 and in_valid=0, the FSM SHALL move to IDLE the next cycle.
REQ-016 In DONE with out_ready=1 and in_valid=1, the result SHALL be released and the new term SHALL start a new group in the same cycle, as in REQ-009 and REQ-011, giving zero bubble.
REQ-017 In DONE with out_ready=0, no term SHALL be accepted and no state SHALL change.
REQ-018 Latency SHALL be one cycle: out_valid rises the cycle after the closing term is accepted.
REQ-019 All arithmetic SHALL be two's complement; ACC_W is sized so a group sum cannot overflow, and no saturation is required.
REQ-020 out_valid SHALL be registered.
REQ-021 out_data and out_count SHALL be 0 whenever out_valid=0.
REQ-022 clear=1 SHALL force IDLE, acc=0 and cnt=0 on the next edge, discarding any partial or held result.
REQ-023 clear SHALL take priority over any handshake in the same cycle.
REQ-024 While clear=1, in_ready SHALL be 0.
REQ-025 in_last received while in DONE with out_ready=0 SHALL have no effect, since no term is accepted.

Reset
REQ-026 When rst_n=0 at a rising clk edge, the state SHALL be IDLE and acc, cnt, out_valid, out_data and out_count SHALL all be 0.
REQ-027 During reset, in_ready SHALL be 0.
REQ-028 rst_n SHALL take priority over clear and over all handshakes.
REQ-029 Reset asserted mid-group SHALL discard the partial sum, and no out_valid SHALL appear afterward until a new group completes.
REQ-030 The first term SHALL be accepted in the first cycle after rst_n returns to 1.

Verification (defaults: IN_W=16, ACC_W=18, CNT_W=3)
REQ-031 The bench SHALL cover: terms 100, -30, 7, in_last on 7, out_ready=1 -> out_valid one cycle later, out_data=77, out_count=3.
REQ-032 The bench SHALL cover: four terms of 0x7FFF with no in_last -> group closes on the 4th term, out_data=0x1FFFC, out_count=4.
REQ-033 The bench SHALL cover: four terms of 0x8000 (-32768) -> out_data=-131072 (0x20000), out_count=4.
REQ-034 The bench SHALL cover: result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable, no term lost; on out_ready=1 the held term starts the next group with zero bubble.
REQ-035 The bench SHALL cover: terms 5, 6, then clear=1 together with in_valid=1 -> no out_valid; next group of single term 9 with in_last -> out_data=9, out_count=1.
REQ-036 The bench SHALL cover: rst_n=0 for one cycle after two terms -> all outputs 0; the following group of 1, 2 with in_last -> out_data=3, out_count=2.

Source files
------------

// File: rtl/shift_accumulator.sv
// Accumulates signed shifted partial products into groups of up to NUM_TERMS terms and
// holds each group sum and term count until the consumer takes them.
module shift_accumulator #(
    parameter int unsigned PARALLELISM = 8,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned NUM_TERMS   = 4,
    localparam int unsigned IN_W  = PARALLELISM + 2**DEPTH,
    localparam int unsigned CNT_W = ($clog2(NUM_TERMS + 1) > 1) ? $clog2(NUM_TERMS + 1) : 1,
    localparam int unsigned ACC_W = IN_W + $clog2(NUM_TERMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(NUM_TERMS);
    localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] in_ext;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;

    assign in_ext = ACC_W'($signed(in_data));

    always_comb begin
        in_ready    = rst_n && !clear && ((state_q != StDone) || out_ready);
        accept      = in_valid && in_ready;
        cnt_inc     = cnt_q + 1'b1;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d   = acc_q + in_ext;
                    cnt_d   = cnt_inc;
                    state_d = (in_last || (cnt_inc == MaxCnt)) ? StDone : StAccum;
                end
            end
            StDone: begin
                // Releasing the result and starting the next group share one cycle.
                if (accept) begin
                    acc_d   = in_ext;
                    cnt_d   = OneCnt;
                    state_d = (in_last || (MaxCnt == OneCnt)) ? StDone : StAccum;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (accept) begin
                    acc_d   = in_ext;
                    cnt_d   = OneCnt;
                    state_d = (in_last || (MaxCnt == OneCnt)) ? StDone : StAccum;
                end
            end
        endcase

        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end

        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? acc_q : '0;
    assign out_count = out_valid_q ? cnt_q : '0;

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed and randomized checks of shift_accumulator against group sums computed
// arithmetically from the term stream.
module tb_shift_accumulator;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned ACC_W = 18;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned NT    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    int errors = 0;
    int checks = 0;

    shift_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [ACC_W-1:0] d,
                             input logic [CNT_W-1:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l,
                         input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted term; in_ready must be high when presented outside DONE/hold.
    task automatic send(input logic [IN_W-1:0] d, input logic l);
        drive(1'b1, d, l, 1'b1, 1'b0);
        #1;
        chk("send_in_ready", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic drain(input string tag);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check_out(tag, 1'b0, '0, '0);
    endtask

    int              exp_sum;
    int              n;
    int              hold;
    logic [IN_W-1:0] t;
    logic            lst;

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check_out("reset", 1'b0, '0, '0);

        // Basic group with in_last; first term accepted right after reset release.
        rst_n = 1'b1;
        send(16'd100, 1'b0);
        chk("g1_pending", 32'(out_valid), 32'd0);
        send(16'(-30), 1'b0);
        send(16'd7, 1'b1);
        check_out("g1", 1'b1, 18'd77, 3'd3);
        drain("g1_idle");

        // Positive full-scale terms close on the term cap.
        for (int i = 0; i < 3; i++) send(16'h7FFF, 1'b0);
        chk("max_pos_pending", 32'(out_valid), 32'd0);
        send(16'h7FFF, 1'b0);
        check_out("max_pos", 1'b1, 18'h1FFFC, 3'd4);
        drain("max_pos_idle");

        for (int i = 0; i < 4; i++) send(16'h8000, 1'b0);
        check_out("max_neg", 1'b1, 18'h20000, 3'd4);
        drain("max_neg_idle");

        // Backpressure: held result stays put, held term is not lost.
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        check_out("bp_first", 1'b1, 18'd3, 3'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'd50, 1'(i % 2), 1'b0, 1'b0);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check_out("bp_hold", 1'b1, 18'd3, 3'd2);
        end
        drive(1'b1, 16'd50, 1'b0, 1'b1, 1'b0);
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        send(16'd60, 1'b1);
        check_out("bp_second", 1'b1, 18'd110, 3'd2);
        drain("bp_idle");

        // Clear mid-group, then clear against a live handshake in DONE.
        send(16'd5, 1'b0);
        send(16'd6, 1'b0);
        drive(1'b1, 16'd8, 1'b1, 1'b1, 1'b1);
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("clr", 1'b0, '0, '0);
        drain("clr_quiet");
        send(16'd9, 1'b1);
        check_out("clr_next", 1'b1, 18'd9, 3'd1);
        drive(1'b1, 16'd44, 1'b1, 1'b1, 1'b1);
        #1;
        chk("clr_done_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("clr_done", 1'b0, '0, '0);
        send(16'd4, 1'b1);
        check_out("clr_done_next", 1'b1, 18'd4, 3'd1);
        drain("clr_done_idle");

        // Reset mid-group discards the partial sum.
        send(16'd11, 1'b0);
        send(16'd22, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 16'd33, 1'b1, 1'b1, 1'b0);
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("mid_rst", 1'b0, '0, '0);
        rst_n = 1'b1;
        send(16'd1, 1'b0);
        chk("mid_rst_pending", 32'(out_valid), 32'd0);
        send(16'd2, 1'b1);
        check_out("mid_rst_next", 1'b1, 18'd3, 3'd2);
        drain("mid_rst_idle");

        // Random groups with random backpressure and optional zero-bubble restarts.
        for (int g = 0; g < 40; g++) begin
            n       = 0;
            exp_sum = 0;
            do begin
                t   = 16'($urandom);
                lst = ($urandom_range(0, 3) == 0);
                n++;
                exp_sum += int'($signed(t));
                send(t, lst);
                if (!(lst || n == NT)) chk("rnd_pending", 32'(out_valid), 32'd0);
            end while (!(lst || n == NT));
            check_out("rnd_result", 1'b1, 18'(exp_sum), 3'(n));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                      1'b0, 1'b0);
                #1;
                chk("rnd_hold_ready", 32'(in_ready), 32'd0);
                tick();
                check_out("rnd_hold", 1'b1, 18'(exp_sum), 3'(n));
            end
            if ($urandom_range(0, 1) == 1) drain("rnd_idle");
        end
        drain("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
